// File: rtl/iccm_axi_master_if.sv
// AXI4 bus between the ICCM master and the ICCM wrapper's s_axi_* slave port.
// The master modport drives requests; the slave modport drives responses.
interface iccm_axi_master_if #(
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4
);
  logic [ADDR_W-1:0] m_axi_awaddr;
  logic [1:0]        m_axi_awburst;
  logic [ID_W-1:0]   m_axi_awid;
  logic [7:0]        m_axi_awlen;
  logic [2:0]        m_axi_awsize;
  logic              m_axi_awvalid;
  logic              m_axi_awready;

  logic [31:0]       m_axi_wdata;
  logic [3:0]        m_axi_wstrb;
  logic              m_axi_wlast;
  logic              m_axi_wvalid;
  logic              m_axi_wready;

  logic [ID_W-1:0]   m_axi_bid;
  logic [1:0]        m_axi_bresp;
  logic              m_axi_bvalid;
  logic              m_axi_bready;

  logic [ADDR_W-1:0] m_axi_araddr;
  logic [1:0]        m_axi_arburst;
  logic [ID_W-1:0]   m_axi_arid;
  logic [7:0]        m_axi_arlen;
  logic [2:0]        m_axi_arsize;
  logic              m_axi_arvalid;
  logic              m_axi_arready;

  logic [31:0]       m_axi_rdata;
  logic [ID_W-1:0]   m_axi_rid;
  logic [1:0]        m_axi_rresp;
  logic              m_axi_rlast;
  logic              m_axi_rvalid;
  logic              m_axi_rready;

  modport master (
    output m_axi_awaddr, m_axi_awburst, m_axi_awid, m_axi_awlen, m_axi_awsize, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bid, m_axi_bresp, m_axi_bvalid,
    output m_axi_bready,
    output m_axi_araddr, m_axi_arburst, m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rid, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output m_axi_rready
  );

  modport slave (
    input  m_axi_awaddr, m_axi_awburst, m_axi_awid, m_axi_awlen, m_axi_awsize, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bid, m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready,
    input  m_axi_araddr, m_axi_arburst, m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rid, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  m_axi_rready
  );
endinterface

// File: rtl/iccm_axi_master.sv
// Single-outstanding AXI4 INCR-burst master turning loader/debug commands into ICCM accesses.
// Define ICCM_AXI_MASTER_TIMEOUT_EN to add a handshake watchdog and the timeout output.
module iccm_axi_master #(
  parameter int ADDR_W         = 32,
  parameter int ID_W           = 4,
  parameter int ID_VAL         = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              s_aclk,
  input  logic              s_aresetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [7:0]        cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [31:0]       wr_data,
  input  logic [3:0]        wr_strb,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [31:0]       rd_data,
  output logic              rd_last,
  output logic              done,
  output logic              err,
  output logic              busy,
`ifdef ICCM_AXI_MASTER_TIMEOUT_EN
  output logic              timeout,
`endif
  iccm_axi_master_if.master axi
);

  localparam logic [ID_W-1:0] ID = ID_W'(ID_VAL);

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_RSP} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_q;
  logic [7:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              rerr_q, rerr_d;
  logic              cmd_ready_c;
  logic              expired;

  // Reject misaligned starts and bursts whose last byte lands past the 4 KB page.
  logic        misaligned;
  logic [13:0] end_off;
  logic        page_cross;
  assign misaligned = (cmd_addr[1:0] != 2'b00);
  assign end_off    = {2'b00, cmd_addr[11:0]} + (({6'b0, cmd_len} + 14'd1) << 2);
  assign page_cross = (end_off > 14'd4096);

  logic last_beat;
  logic r_bad;
  assign last_beat = (cnt_q == len_q);
  assign r_bad     = (axi.m_axi_rresp != 2'b00) || (axi.m_axi_rid != ID) ||
                     (axi.m_axi_rlast != last_beat);

  assign axi.m_axi_awaddr  = addr_q;
  assign axi.m_axi_awburst = 2'b01;
  assign axi.m_axi_awid    = ID;
  assign axi.m_axi_awlen   = len_q;
  assign axi.m_axi_awsize  = 3'b010;
  assign axi.m_axi_araddr  = addr_q;
  assign axi.m_axi_arburst = 2'b01;
  assign axi.m_axi_arid    = ID;
  assign axi.m_axi_arlen   = len_q;
  assign axi.m_axi_arsize  = 3'b010;
  assign axi.m_axi_wdata   = wr_data;
  assign axi.m_axi_wstrb   = wr_strb;
  assign rd_data           = axi.m_axi_rdata;

  assign cmd_ready = cmd_ready_c & s_aresetn;
  assign done      = (state_q == S_RSP);
  assign busy      = (state_q != S_IDLE);
  assign err       = err_q;

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    err_d             = err_q;
    rerr_d            = rerr_q;
    cmd_ready_c       = 1'b0;
    wr_ready          = 1'b0;
    rd_valid          = 1'b0;
    rd_last           = 1'b0;
    axi.m_axi_awvalid = 1'b0;
    axi.m_axi_wvalid  = 1'b0;
    axi.m_axi_wlast   = 1'b0;
    axi.m_axi_bready  = 1'b0;
    axi.m_axi_arvalid = 1'b0;
    axi.m_axi_rready  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cmd_ready_c = 1'b1;
        if (cmd_valid) begin
          cnt_d  = 8'd0;
          rerr_d = 1'b0;
          if (misaligned || page_cross) begin
            err_d   = 1'b1;
            state_d = S_RSP;
          end else begin
            state_d = cmd_write ? S_AW : S_AR;
          end
        end
      end
      S_AW: begin
        axi.m_axi_awvalid = 1'b1;
        if (axi.m_axi_awready) state_d = S_W;
      end
      S_W: begin
        axi.m_axi_wvalid = wr_valid;
        axi.m_axi_wlast  = last_beat;
        wr_ready         = axi.m_axi_wready;
        if (wr_valid && axi.m_axi_wready) begin
          cnt_d = cnt_q + 8'd1;
          if (last_beat) state_d = S_B;
        end
      end
      S_B: begin
        axi.m_axi_bready = 1'b1;
        if (axi.m_axi_bvalid) begin
          err_d   = (axi.m_axi_bresp != 2'b00) || (axi.m_axi_bid != ID);
          state_d = S_RSP;
        end
      end
      S_AR: begin
        axi.m_axi_arvalid = 1'b1;
        if (axi.m_axi_arready) state_d = S_R;
      end
      S_R: begin
        rd_valid         = axi.m_axi_rvalid;
        rd_last          = axi.m_axi_rlast;
        axi.m_axi_rready = rd_ready;
        if (axi.m_axi_rvalid && rd_ready) begin
          cnt_d  = cnt_q + 8'd1;
          rerr_d = rerr_q | r_bad;
          // Finish on our own beat count; a wrong rlast only shows up as an error.
          if (last_beat) begin
            err_d   = rerr_q | r_bad;
            state_d = S_RSP;
          end
        end
      end
      S_RSP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (expired) begin
      wr_ready          = 1'b0;
      rd_valid          = 1'b0;
      rd_last           = 1'b0;
      axi.m_axi_awvalid = 1'b0;
      axi.m_axi_wvalid  = 1'b0;
      axi.m_axi_bready  = 1'b0;
      axi.m_axi_arvalid = 1'b0;
      axi.m_axi_rready  = 1'b0;
      err_d             = 1'b1;
      state_d           = S_RSP;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge s_aclk) begin
    if (!s_aresetn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= 8'd0;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rerr_q  <= rerr_d;
      if (cmd_valid && cmd_ready_c) begin
        addr_q <= cmd_addr;
        len_q  <= cmd_len;
      end
    end
  end

`ifdef ICCM_AXI_MASTER_TIMEOUT_EN
  logic [15:0] wd_q;
  logic        timeout_q;
  logic        active;
  logic        axi_hs;

  assign active  = (state_q == S_AW) || (state_q == S_W) || (state_q == S_B) ||
                   (state_q == S_AR) || (state_q == S_R);
  assign axi_hs  = (axi.m_axi_awvalid && axi.m_axi_awready) ||
                   (axi.m_axi_wvalid  && axi.m_axi_wready)  ||
                   (axi.m_axi_bvalid  && axi.m_axi_bready)  ||
                   (axi.m_axi_arvalid && axi.m_axi_arready) ||
                   (axi.m_axi_rvalid  && axi.m_axi_rready);
  assign expired = active && (wd_q == 16'(TIMEOUT_CYCLES));
  assign timeout = timeout_q;

  // timeout_q is high only in the RSP cycle that an expiry forces.
  always_ff @(posedge s_aclk) begin
    if (!s_aresetn) begin
      wd_q      <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= expired;
      if (!active || axi_hs || expired) wd_q <= 16'd0;
      else                              wd_q <= wd_q + 16'd1;
    end
  end
`else
  assign expired = 1'b0;
`endif

endmodule

// File: tb/tb_iccm_axi_master.sv
// Directed bench for iccm_axi_master: behavioural ICCM slave plus a read-data scoreboard.
module tb_iccm_axi_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        rd_valid, rd_ready, rd_last;
  logic [31:0] rd_data;
  logic        done, err, busy;
`ifdef ICCM_AXI_MASTER_TIMEOUT_EN
  logic        timeout;
`endif

  always #5 clk = ~clk;

  iccm_axi_master_if #(.ADDR_W(32), .ID_W(4)) axi ();

  iccm_axi_master #(.ADDR_W(32), .ID_W(4), .ID_VAL(1), .TIMEOUT_CYCLES(1024)) dut (
    .s_aclk    (clk),
    .s_aresetn (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .wr_strb   (wr_strb),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rd_last   (rd_last),
    .done      (done),
    .err       (err),
    .busy      (busy),
`ifdef ICCM_AXI_MASTER_TIMEOUT_EN
    .timeout   (timeout),
`endif
    .axi       (axi)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  // ---------------- behavioural ICCM slave ----------------
  logic [31:0] mem [0:1023];
  int          ar_delay = 0;
  int          ar_wait;
  logic [1:0]  bresp_inj = 2'b00;
  logic [31:0] aw_addr_s, ar_addr_s;
  logic [7:0]  wcnt_s, rlen_s, rcnt_s;

  function automatic int widx(input logic [31:0] a, input int off);
    return (int'(a[11:2]) + off) & 1023;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  assign axi.m_axi_awready = 1'b1;
  assign axi.m_axi_wready  = 1'b1;
  assign axi.m_axi_arready = (ar_wait >= ar_delay);
  assign axi.m_axi_bid     = 4'd1;
  assign axi.m_axi_rid     = 4'd1;
  assign axi.m_axi_rresp   = 2'b00;

  always @(posedge clk) begin
    if (!rst_n) begin
      axi.m_axi_bvalid <= 1'b0;
      axi.m_axi_bresp  <= 2'b00;
      axi.m_axi_rvalid <= 1'b0;
      axi.m_axi_rlast  <= 1'b0;
      axi.m_axi_rdata  <= 32'd0;
      ar_wait          <= 0;
      wcnt_s           <= 8'd0;
    end else begin
      if (axi.m_axi_awvalid && axi.m_axi_awready) begin
        aw_addr_s <= axi.m_axi_awaddr;
        wcnt_s    <= 8'd0;
      end
      if (axi.m_axi_wvalid && axi.m_axi_wready) begin
        mem[widx(aw_addr_s, int'(wcnt_s))] <= merge(mem[widx(aw_addr_s, int'(wcnt_s))],
                                                    axi.m_axi_wdata, axi.m_axi_wstrb);
        wcnt_s <= wcnt_s + 8'd1;
        if (axi.m_axi_wlast) begin
          axi.m_axi_bvalid <= 1'b1;
          axi.m_axi_bresp  <= bresp_inj;
        end
      end
      if (axi.m_axi_bvalid && axi.m_axi_bready) axi.m_axi_bvalid <= 1'b0;
      if (axi.m_axi_arvalid && !axi.m_axi_arready) ar_wait <= ar_wait + 1;
      if (axi.m_axi_arvalid && axi.m_axi_arready) begin
        ar_wait          <= 0;
        ar_addr_s        <= axi.m_axi_araddr;
        rlen_s           <= axi.m_axi_arlen;
        rcnt_s           <= 8'd0;
        axi.m_axi_rvalid <= 1'b1;
        axi.m_axi_rdata  <= mem[widx(axi.m_axi_araddr, 0)];
        axi.m_axi_rlast  <= (axi.m_axi_arlen == 8'd0);
      end
      if (axi.m_axi_rvalid && axi.m_axi_rready) begin
        if (rcnt_s == rlen_s) begin
          axi.m_axi_rvalid <= 1'b0;
          axi.m_axi_rlast  <= 1'b0;
        end else begin
          rcnt_s          <= rcnt_s + 8'd1;
          axi.m_axi_rdata <= mem[widx(ar_addr_s, int'(rcnt_s) + 1)];
          axi.m_axi_rlast <= ((rcnt_s + 8'd1) == rlen_s);
        end
      end
    end
  end

  // ---------------- scoreboard and monitors ----------------
  typedef struct {
    logic [31:0] data;
    logic        last;
  } rd_exp_t;

  rd_exp_t     exp_q[$];
  logic [31:0] ref_mem [0:1023];
  logic [31:0] wbuf [0:255];
  int          cur_len = 0;
  int          wbeat = 0;
  int          rd_hs = 0;
  int          aw_cycles = 0;
  int          axi_act = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (axi.m_axi_awvalid) aw_cycles++;
      if (axi.m_axi_awvalid || axi.m_axi_wvalid || axi.m_axi_arvalid ||
          axi.m_axi_bready || axi.m_axi_rready) axi_act++;
      if (axi.m_axi_wvalid && axi.m_axi_wready) begin
        check($sformatf("wlast_beat%0d", wbeat), 32'(axi.m_axi_wlast), 32'(wbeat == cur_len));
        wbeat++;
      end
      if (rd_valid && rd_ready) begin
        rd_hs++;
        check("rd_beat_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          rd_exp_t e;
          e = exp_q.pop_front();
          check("rd_data", rd_data, e.data);
          check("rd_last", 32'(rd_last), 32'(e.last));
        end
      end
    end
  end

  // ---------------- command driver ----------------
  logic [3:0] rd_pat = 4'b1001;  // rd_ready sequence 1,0,0,1 (bit 0 first)

  task automatic run_cmd(input bit wr, input logic [31:0] addr, input logic [7:0] len,
                         input bit exp_err, input int exp_cyc, input bit stall);
    bit hs, seen, whs;
    int cyc, beat, guard;
    logic obs_err;
    cur_len = int'(len);
    wbeat   = 0;
    obs_err = 1'b0;
    if (!exp_err) begin
      for (int i = 0; i <= int'(len); i++) begin
        if (wr) ref_mem[widx(addr, i)] = wbuf[i];
        else    exp_q.push_back('{data: ref_mem[widx(addr, i)], last: (i == int'(len))});
      end
    end
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_len   = len;
    hs = 1'b0;
    guard = 0;
    while (!hs && guard < 50) begin
      @(negedge clk);
      hs = cmd_ready;
      @(posedge clk); #1;
      guard++;
    end
    cmd_valid = 1'b0;
    check("cmd_accept", 32'(hs), 32'd1);
    beat = 0;
    cyc  = 1;
    seen = 1'b0;
    while (!seen && cyc < 2000) begin
      wr_valid = wr && (beat <= int'(len));
      wr_data  = wbuf[beat & 255];
      wr_strb  = 4'hF;
      rd_ready = stall ? rd_pat[(cyc - 1) % 4] : 1'b1;
      @(negedge clk);
      seen    = done;
      obs_err = err;
      whs     = wr_valid && wr_ready;
      @(posedge clk); #1;
      if (whs) beat++;
      if (!seen) cyc++;
    end
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    check("done_seen", 32'(seen), 32'd1);
    check("done_err", 32'(obs_err), 32'(exp_err));
    if (exp_cyc > 0) check("done_latency", 32'(cyc), 32'(exp_cyc));
    if (!wr) check("rd_all_beats", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int beat, guard;
    bit whs;
    rst_n = 1'b0;  cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'd0; cmd_len = 8'd0;
    wr_valid = 1'b0; wr_data = 32'd0; wr_strb = 4'h0; rd_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_valids", 32'({axi.m_axi_awvalid, axi.m_axi_wvalid, axi.m_axi_arvalid,
                             axi.m_axi_bready, axi.m_axi_rready, rd_valid, rd_last}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    // single write then read back, zero-wait latency
    wbuf[0] = 32'hDEADBEEF;
    aw_cycles = 0;
    run_cmd(1'b1, 32'h10, 8'd0, 1'b0, 4, 1'b0);
    check("single_wr_aw_once", 32'(aw_cycles), 32'd1);
    run_cmd(1'b0, 32'h10, 8'd0, 1'b0, 3, 1'b0);

    // 4-beat burst
    for (int i = 0; i < 4; i++) wbuf[i] = 32'h11111111 * (i + 1);
    run_cmd(1'b1, 32'h100, 8'd3, 1'b0, -1, 1'b0);
    run_cmd(1'b0, 32'h100, 8'd3, 1'b0, -1, 1'b0);

    // 8-beat read with rd_ready backpressure and delayed arready
    for (int i = 0; i < 8; i++) wbuf[i] = 32'hC0DE0000 + 32'(i * 7);
    run_cmd(1'b1, 32'h200, 8'd7, 1'b0, -1, 1'b0);
    aw_cycles = 0;
    rd_hs     = 0;
    ar_delay  = 3;
    run_cmd(1'b0, 32'h200, 8'd7, 1'b0, -1, 1'b1);
    ar_delay  = 0;
    check("bp_rd_handshakes", 32'(rd_hs), 32'd8);
    check("bp_no_awvalid", 32'(aw_cycles), 32'd0);

    // rejected commands: misaligned and 4 KB page crossing
    axi_act = 0;
    run_cmd(1'b1, 32'h12, 8'd0, 1'b1, 1, 1'b0);
    check("rej_misaligned_no_axi", 32'(axi_act), 32'd0);
    axi_act = 0;
    run_cmd(1'b0, 32'hFF8, 8'd3, 1'b1, 1, 1'b0);
    check("rej_page_no_axi", 32'(axi_act), 32'd0);
    axi_act = 0;
    run_cmd(1'b0, 32'hFF0, 8'd3, 1'b0, -1, 1'b0);  // ends exactly at 4096: allowed
    check("edge_page_axi_used", 32'(axi_act != 0), 32'd1);

    // slave error response, sticky until the next done, then a clean write
    bresp_inj = 2'b10;
    wbuf[0]   = 32'h0BAD0BAD;
    run_cmd(1'b1, 32'h300, 8'd0, 1'b1, 4, 1'b0);
    bresp_inj = 2'b00;
    @(negedge clk);
    check("err_hold_value", 32'(err), 32'd1);
    check("err_hold_no_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    wbuf[0] = 32'h600DF00D;
    run_cmd(1'b1, 32'h304, 8'd0, 1'b0, 4, 1'b0);

    // 256-beat burst: counter must not wrap early
    for (int i = 0; i < 256; i++) wbuf[i] = 32'hA5000000 ^ 32'(i * 32'h00010101);
    run_cmd(1'b1, 32'h400, 8'd255, 1'b0, -1, 1'b0);
    rd_hs = 0;
    run_cmd(1'b0, 32'h400, 8'd255, 1'b0, -1, 1'b0);
    check("long_rd_handshakes", 32'(rd_hs), 32'd256);

    // reset during beat 2 of a 4-beat write
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hEE000000 + 32'(i);
    cur_len = 3;
    wbeat = 0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h100; cmd_len = 8'd3;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    beat = 0;
    guard = 0;
    while (beat < 2 && guard < 50) begin
      wr_valid = 1'b1;
      wr_data  = wbuf[beat];
      wr_strb  = 4'hF;
      @(negedge clk);
      whs = wr_valid && wr_ready;
      @(posedge clk); #1;
      if (whs) beat++;
      guard++;
    end
    check("rst_mid_two_beats", 32'(beat), 32'd2);
    check("rst_mid_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_valids", 32'({axi.m_axi_awvalid, axi.m_axi_wvalid, axi.m_axi_arvalid,
                                 axi.m_axi_bready, axi.m_axi_rready, wr_ready}), 32'd0);
    wr_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    wbuf[0] = 32'h12345678;
    run_cmd(1'b1, 32'h10, 8'd0, 1'b0, 4, 1'b0);
    run_cmd(1'b0, 32'h10, 8'd0, 1'b0, 3, 1'b0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
